instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Front end of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Latches each fetched word plus PC+4 into the IF/ID register, whose immediate field [15:0] feeds sig_extend in decode.
- Handles hazard stall, branch/jump redirect, wrong-path flush, debug step-enable and a sticky halt state.

Parameters:
- PC_SIZE, 32, width of PC and all address ports.
- INSTRUCTION_SIZE, 32, width of instruction words.
- HALT_INSTRUCTION, 32'hFFFFFFFF, encoding that stops fetch.
- NOP_INSTRUCTION, 32'h00000000, word inserted into IF/ID on flush.

Ports:
- i_clk  in  1  pipeline clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  global step enable from the debug unit; 0 freezes the block.
- i_stall  in  1  load-use hazard; hold PC and IF/ID.
- i_flush  in  1  replace the IF/ID contents with NOP (wrong path).
- i_jump  in  1  unconditional redirect request.
- i_jump_addr  in  PC_SIZE  jump target.
- i_branch_taken  in  1  resolved taken branch.
- i_branch_addr  in  PC_SIZE  branch target.
- o_imem_addr  out  PC_SIZE  current PC, combinational from the PC register.
- i_imem_data  in  INSTRUCTION_SIZE  instruction at o_imem_addr, combinational read.
- o_instruction  out  INSTRUCTION_SIZE  IF/ID instruction.
- o_pc_next  out  PC_SIZE  IF/ID PC+4.
- o_valid  out  1  IF/ID holds a real (non-flushed) instruction.
- o_halt  out  1  block is in HALT.

Behaviour:
- Reset (asynchronous, active-high): PC=0, o_instruction=NOP, o_pc_next=0, o_valid=0, o_halt=0, state=RUN. Reset mid-operation aborts everything immediately; any pending redirect is discarded.
- FSM states: RUN and HALT.
  - RUN -> HALT on an "advance" edge (defined below) with i_imem_data==HALT_INSTRUCTION and i_flush=0.
  - HALT -> RUN only by reset.
- Per rising edge in RUN, highest priority first:
  1. i_enable=0: everything holds.
  2. Redirect (i_jump=1, or i_branch_taken=1): PC <= i_jump_addr if i_jump, else i_branch_addr. i_jump wins when both are set. Redirect overrides i_stall.
     - IF/ID <= {NOP, PC+4, valid=0}. The fetched word is wrong-path.
  3. i_stall=1: PC and IF/ID hold.
  4. Otherwise this is an "advance": PC <= PC+4 and IF/ID <= {i_imem_data, PC+4, valid=1}.
- PC arithmetic:
  - PC+4 is modulo 2^PC_SIZE; 32'hFFFFFFFC wraps to 0 with no flag.
  - The PC register bits [1:0] are forced to 0 on every load, including redirect targets.
- i_flush (ignored while i_enable=0):
  - On an edge with i_enable=1, IF/ID <= {NOP, 0, valid=0}, regardless of stall.
  - Flush does not block a PC update: PC still follows rules 2-4.
  - Flush suppresses HALT entry on that edge. The PC still advances, so the halt word is refetched only after a redirect back to it.
- HALT entry edge:
  - IF/ID latches the halt word with valid=1, so downstream sees it.
  - PC does NOT advance: PC stays at the halt address.
  - o_halt=1 from the next cycle.
- In HALT: PC, IF/ID and o_halt are frozen. i_stall, i_flush, i_jump, i_branch_taken and i_enable are all ignored.
- Latency: the word at PC appears on o_instruction one edge after an advance. A redirect target's word appears two edges after the redirect edge.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined:
  - Adds port o_fetch_count (out, 32).
  - Reset value 0.
  - Increments on every edge where IF/ID loads valid=1, including the halt word.
  - Saturates at 32'hFFFFFFFF.
  - Holds in HALT.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then sequential fetch: memory word at 0 = 32'h20010005, at 4 = 32'h20020007; i_enable=1 -> after edge 1 o_instruction=32'h20010005, o_pc_next=4, o_valid=1; after edge 2 o_instruction=32'h20020007, o_pc_next=8, o_imem_addr=8.
- Stall vs redirect: with PC=8 hold i_stall=1 for 3 edges -> PC stays 8 and IF/ID unchanged. Then assert i_stall=1 together with i_branch_taken=1, i_branch_addr=32'h40 -> PC=32'h40, o_valid=0, o_instruction=0.
- Jump priority: i_jump=1 with i_jump_addr=32'h100 and i_branch_taken=1 with i_branch_addr=32'h200 -> PC=32'h100. A target of 32'h103 loads PC=32'h100.
- Flush suppresses halt: PC=32'h10 holding 32'hFFFFFFFF with i_flush=1 -> o_halt stays 0, o_valid=0, PC=32'h14.
- Halt: same setup with i_flush=0 -> o_instruction=32'hFFFFFFFF, o_valid=1, PC=32'h10 and o_halt=1 thereafter. Afterwards i_jump, i_stall and i_flush change nothing. i_reset=1 asserted mid-cycle clears PC and o_halt immediately, without waiting for a clock edge.
- Edge cases:
  - PC=32'hFFFFFFFC advance -> PC=0, o_pc_next=0.
  - i_enable=0 for 5 edges -> nothing changes.
  - With FETCH_COUNT_EN: 4 advances, 1 flush, 1 stall -> o_fetch_count=4.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC register, IF/ID register, RUN/HALT control.
// Optional retired-fetch counter on o_fetch_count when FETCH_COUNT_EN is defined.
module instruction_fetch #(
    parameter int                              PC_SIZE          = 32,
    parameter int                              INSTRUCTION_SIZE = 32,
    parameter logic [INSTRUCTION_SIZE-1:0]     HALT_INSTRUCTION = 32'hFFFFFFFF,
    parameter logic [INSTRUCTION_SIZE-1:0]     NOP_INSTRUCTION  = 32'h00000000
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_stall,
    input  logic                        i_flush,
    input  logic                        i_jump,
    input  logic [PC_SIZE-1:0]          i_jump_addr,
    input  logic                        i_branch_taken,
    input  logic [PC_SIZE-1:0]          i_branch_addr,
    output logic [PC_SIZE-1:0]          o_imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] i_imem_data,
    output logic [INSTRUCTION_SIZE-1:0] o_instruction,
    output logic [PC_SIZE-1:0]          o_pc_next,
    output logic                        o_valid,
    output logic                        o_halt
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]                 o_fetch_count
`endif
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [PC_SIZE-1:0] PC_STEP    = {{(PC_SIZE-3){1'b0}}, 3'b100};
    localparam logic [PC_SIZE-1:0] ALIGN_MASK = {{(PC_SIZE-2){1'b1}}, 2'b00};

    state_t                        state_r;
    state_t                        state_next_s;
    logic [PC_SIZE-1:0]            pc_r;
    logic [PC_SIZE-1:0]            pc_load_s;
    logic [PC_SIZE-1:0]            pc_plus4_s;
    logic [INSTRUCTION_SIZE-1:0]   instr_r;
    logic [INSTRUCTION_SIZE-1:0]   instr_load_s;
    logic [PC_SIZE-1:0]            pc_next_r;
    logic [PC_SIZE-1:0]            pc_next_load_s;
    logic                          valid_r;
    logic                          valid_load_s;
    logic                          run_s;
    logic                          redirect_s;
    logic                          advance_s;
    logic                          halt_hit_s;

    // Qualify this edge's action: frozen, redirect, stall, or advance.
    always_comb begin
        pc_plus4_s = pc_r + PC_STEP;
        run_s      = (state_r == ST_RUN) && i_enable;
        redirect_s = run_s && (i_jump || i_branch_taken);
        advance_s  = run_s && !redirect_s && !i_stall;
        halt_hit_s = advance_s && !i_flush && (i_imem_data == HALT_INSTRUCTION);
    end

    // State register; HALT is left only through reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_hit_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_RUN;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        o_halt        = (state_r == ST_HALT);
        o_imem_addr   = pc_r;
        o_instruction = instr_r;
        o_pc_next     = pc_next_r;
        o_valid       = valid_r;
    end

    // PC next value: the halt word keeps PC parked on its own address.
    always_comb begin
        pc_load_s = pc_r;
        if (redirect_s) begin
            if (i_jump) begin
                pc_load_s = i_jump_addr & ALIGN_MASK;
            end else begin
                pc_load_s = i_branch_addr & ALIGN_MASK;
            end
        end else if (advance_s && !halt_hit_s) begin
            pc_load_s = pc_plus4_s & ALIGN_MASK;
        end else begin
            pc_load_s = pc_r;
        end
    end

    // IF/ID next value: flush beats redirect beats advance.
    always_comb begin
        instr_load_s   = instr_r;
        pc_next_load_s = pc_next_r;
        valid_load_s   = valid_r;
        if (run_s && i_flush) begin
            instr_load_s   = NOP_INSTRUCTION;
            pc_next_load_s = {PC_SIZE{1'b0}};
            valid_load_s   = 1'b0;
        end else if (redirect_s) begin
            instr_load_s   = NOP_INSTRUCTION;
            pc_next_load_s = pc_plus4_s;
            valid_load_s   = 1'b0;
        end else if (advance_s) begin
            instr_load_s   = i_imem_data;
            pc_next_load_s = pc_plus4_s;
            valid_load_s   = 1'b1;
        end else begin
            instr_load_s   = instr_r;
            pc_next_load_s = pc_next_r;
            valid_load_s   = valid_r;
        end
    end

    // PC and IF/ID registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_r      <= {PC_SIZE{1'b0}};
            instr_r   <= NOP_INSTRUCTION;
            pc_next_r <= {PC_SIZE{1'b0}};
            valid_r   <= 1'b0;
        end else begin
            pc_r      <= pc_load_s;
            instr_r   <= instr_load_s;
            pc_next_r <= pc_next_load_s;
            valid_r   <= valid_load_s;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_r;
    logic        count_inc_s;

    // A valid IF/ID load is an advance that no flush cancelled.
    always_comb begin
        count_inc_s   = advance_s && !i_flush;
        o_fetch_count = fetch_count_r;
    end

    // Saturating count of valid IF/ID loads.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fetch_count_r <= 32'h00000000;
        end else if (count_inc_s && (fetch_count_r != 32'hFFFFFFFF)) begin
            fetch_count_r <= fetch_count_r + 32'h00000001;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected IF/ID/PC/halt values are queued per step
// and compared after the following clock edge.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        flush;
    logic        jump;
    logic [31:0] jump_addr;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic [31:0] pc_next;
    logic        valid;
    logic        halt;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [31:0] pcn;
        logic        vld;
        logic [31:0] addr;
        logic        hlt;
    } exp_t;

    exp_t sb[$];

    instruction_fetch dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_stall        (stall),
        .i_flush        (flush),
        .i_jump         (jump),
        .i_jump_addr    (jump_addr),
        .i_branch_taken (branch_taken),
        .i_branch_addr  (branch_addr),
        .o_imem_addr    (imem_addr),
        .i_imem_data    (imem_data),
        .o_instruction  (instruction),
        .o_pc_next      (pc_next),
        .o_valid        (valid),
        .o_halt         (halt)
`ifdef FETCH_COUNT_EN
        ,
        .o_fetch_count  (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00000000: return 32'h20010005;
            32'h00000004: return 32'h20020007;
            32'h00000010: return 32'hFFFFFFFF;
            default:      return a + 32'h10000000;
        endcase
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] instr, input logic [31:0] pcn,
                        input logic vld, input logic [31:0] addr, input logic hlt);
        exp_t e;
        e.tag = tag; e.instr = instr; e.pcn = pcn; e.vld = vld; e.addr = addr; e.hlt = hlt;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".instr"}, instruction, e.instr);
        chk({e.tag, ".pc_next"}, pc_next, e.pcn);
        chk({e.tag, ".valid"}, {31'd0, valid}, {31'd0, e.vld});
        chk({e.tag, ".addr"}, imem_addr, e.addr);
        chk({e.tag, ".halt"}, {31'd0, halt}, {31'd0, e.hlt});
    endtask

    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pcn,
                        input logic vld, input logic [31:0] addr, input logic hlt);
        push(tag, instr, pcn, vld, addr, hlt);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle();
        stall = 1'b0; flush = 1'b0; jump = 1'b0; branch_taken = 1'b0; enable = 1'b1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; stall = 1'b0; flush = 1'b0;
        jump = 1'b0; jump_addr = 32'h0; branch_taken = 1'b0; branch_addr = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        push("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        compare();
        reset = 1'b0;

        step("fetch0", 32'h20010005, 32'h4, 1'b1, 32'h4, 1'b0);
        step("fetch1", 32'h20020007, 32'h8, 1'b1, 32'h8, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall", 32'h20020007, 32'h8, 1'b1, 32'h8, 1'b0);
        branch_taken = 1'b1; branch_addr = 32'h40;
        step("stall_branch", 32'h0, 32'hC, 1'b0, 32'h40, 1'b0);
        idle();
        step("fetch40", 32'h10000040, 32'h44, 1'b1, 32'h44, 1'b0);

        jump = 1'b1; jump_addr = 32'h100; branch_taken = 1'b1; branch_addr = 32'h200;
        step("jump_prio", 32'h0, 32'h48, 1'b0, 32'h100, 1'b0);
        branch_taken = 1'b0; jump_addr = 32'h103;
        step("jump_align", 32'h0, 32'h104, 1'b0, 32'h100, 1'b0);
        jump = 1'b0; branch_taken = 1'b1; branch_addr = 32'h10;
        step("branch10", 32'h0, 32'h104, 1'b0, 32'h10, 1'b0);

        idle(); flush = 1'b1;
        step("flush_halt", 32'h0, 32'h0, 1'b0, 32'h14, 1'b0);
        idle();
        step("fetch14", 32'h10000014, 32'h18, 1'b1, 32'h18, 1'b0);

        enable = 1'b0; jump = 1'b1; jump_addr = 32'h300; flush = 1'b1; stall = 1'b1;
        for (int i = 0; i < 5; i++) step("disabled", 32'h10000014, 32'h18, 1'b1, 32'h18, 1'b0);

        idle(); branch_taken = 1'b1; branch_addr = 32'hFFFFFFFC;
        step("branch_top", 32'h0, 32'h1C, 1'b0, 32'hFFFFFFFC, 1'b0);
        idle();
        step("wrap", 32'h0FFFFFFC, 32'h0, 1'b1, 32'h0, 1'b0);
        branch_taken = 1'b1; branch_addr = 32'h10;
        step("back10", 32'h0, 32'h4, 1'b0, 32'h10, 1'b0);
        idle();
        step("halt_entry", 32'hFFFFFFFF, 32'h14, 1'b1, 32'h10, 1'b1);

        jump = 1'b1; jump_addr = 32'h300; stall = 1'b1; flush = 1'b1; branch_taken = 1'b1;
        branch_addr = 32'h80;
        for (int i = 0; i < 3; i++) step("halted", 32'hFFFFFFFF, 32'h14, 1'b1, 32'h10, 1'b1);
`ifdef FETCH_COUNT_EN
        chk("fetch_count", fetch_count, 32'd6);
`endif

        idle();
        #3;
        reset = 1'b1;
        #1;
        push("async_reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        compare();
`ifdef FETCH_COUNT_EN
        chk("fetch_count_rst", fetch_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("restart", 32'h20010005, 32'h4, 1'b1, 32'h4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
